// File: rtl/ps2_frame_rx_pkg.sv
// ps2_frame_rx shared types and frame constants.
// Imported by the receiver top and its line filter.
package ps2_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: synchroniser chain plus
// a run-length debounce on the synced sample.
module ps2_line_filter
  import ps2_frame_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // flip only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 1'b1;
      cnt  <= '0;
    end else if (synced == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      filt <= synced;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: 11-bit frames,
// good bytes as a ready pulse, errors as separate pulses.
module ps2_frame_rx
  import ps2_frame_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ready,
  output logic [7:0] scancode,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic [7:0] err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fc;
  logic          fd;
  logic          fc_q;
  logic          fall;
  state_t        state;
  state_t        state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          start_bit;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          ready_n;
  logic          perr_n;
  logic          ferr_n;
  logic          terr_n;
  logic          err_any;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (ps2_clk),
    .filt (fc)
  );

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (ps2_data),
    .filt (fd)
  );

  assign fall    = fc_q & ~fc;
  assign tmo_hit = (state != IDLE) &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_any = perr_n | ferr_n | terr_n;

  always_comb begin
    state_n = state;
    ready_n = 1'b0;
    perr_n  = 1'b0;
    ferr_n  = 1'b0;
    terr_n  = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: state_n = DATA;
        DATA: begin
          if (bit_cnt == 3'(DATA_BITS - 1))
            state_n = PARITY;
        end
        PARITY: state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (start_bit != START_BIT ||
              fd != STOP_BIT)
            ferr_n = 1'b1;
          else if (!(^{shreg, parity_bit}))
            perr_n = 1'b1;
          else
            ready_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (tmo_hit) begin
      terr_n  = 1'b1;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fc_q        <= 1'b1;
      ready       <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      scancode    <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      fc_q        <= fc;
      ready       <= ready_n;
      parity_err  <= perr_n;
      frame_err   <= ferr_n;
      timeout_err <= terr_n;
      if (ready_n)
        scancode <= shreg;
      if (err_any && err_count != 8'hFF)
        err_count <= err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      start_bit  <= 1'b0;
      parity_bit <= 1'b0;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          start_bit <= fd;
          bit_cnt   <= '0;
        end
        DATA: begin
          shreg   <= {fd, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: parity_bit <= fd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (fall || state == IDLE || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: good, bad-parity,
// framing, timeout, glitch and mid-frame reset cases.
module tb_ps2_frame_rx;
  import ps2_frame_rx_pkg::*;

  localparam int HALF = 6;
  localparam int TMO  = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready;
  logic [7:0] scancode;
  logic       parity_err;
  logic       frame_err;
  logic       timeout_err;
  logic [7:0] err_count;

  int n_chk = 0;
  int n_ok  = 0;
  int lat   = 0;

  int n_rdy = 0;
  int n_pe  = 0;
  int n_fe  = 0;
  int n_te  = 0;
  int run   = 0;
  int max_w = 0;

  ps2_frame_rx #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ready      (ready),
    .scancode   (scancode),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    n_rdy = n_rdy + int'(ready);
    n_pe  = n_pe + int'(parity_err);
    n_fe  = n_fe + int'(frame_err);
    n_te  = n_te + int'(timeout_err);
    if (ready | parity_err | frame_err | timeout_err)
      run = run + 1;
    else
      run = 0;
    if (run > max_w)
      max_w = run;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_ok++;
    else
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      @(negedge clk);
  endtask

  task automatic clk_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic par,
                            input logic stp,
                            input logic strt);
    clk_bit(strt);
    for (int i = 0; i < 8; i++)
      clk_bit(d[i]);
    clk_bit(par);
    ps2_data = stp;
    idle(HALF);
    ps2_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (lat == 0 && (ready | parity_err |
                       frame_err | timeout_err))
        lat = k;
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    idle(10);
  endtask

  int r0, p0, f0, t0;

  task automatic snap();
    r0 = n_rdy; p0 = n_pe; f0 = n_fe; t0 = n_te;
  endtask

  initial begin
    idle(3);
    check("rst_out", {28'd0, ready, parity_err,
          frame_err, timeout_err}, 32'd0);
    check("rst_sc", 32'(scancode), 32'd0);
    check("rst_ec", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    idle(5);
    check("rst_st", 32'(dut.state), 32'(IDLE));

    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("g1_rdy", n_rdy - r0, 1);
    check("g1_sc", 32'(scancode), 32'h1C);
    check("g1_err", n_pe + n_fe + n_te - p0 - f0 - t0, 0);
    check("g1_ec", 32'(err_count), 32'd0);
    check("g1_lat", lat, 7);

    snap();
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    check("b2b_sc0", 32'(scancode), 32'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("b2b_sc1", 32'(scancode), 32'h1C);
    check("b2b_rdy", n_rdy - r0, 2);
    check("b2b_w", max_w, 1);

    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    check("par_pe", n_pe - p0, 1);
    check("par_rdy", n_rdy - r0, 0);
    check("par_sc", 32'(scancode), 32'h1C);
    check("par_ec", 32'(err_count), 32'd1);

    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("stp_fe", n_fe - f0, 1);
    check("stp_rdy", n_rdy - r0, 0);
    check("stp_ec", 32'(err_count), 32'd2);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check("sta_fe", n_fe - f0, 2);
    check("sta_ec", 32'(err_count), 32'd3);
    for (int i = 0; i < 254; i++)
      send_frame(8'(i), 1'b1, 1'b0, 1'b0);
    check("sat_fe", n_fe - f0, 256);
    check("sat_ec", 32'(err_count), 32'd255);
    check("sat_w", max_w, 1);

    snap();
    clk_bit(1'b0);
    clk_bit(1'b1);
    clk_bit(1'b0);
    clk_bit(1'b1);
    idle(TMO + 10);
    check("tmo_te", n_te - t0, 1);
    check("tmo_st", 32'(dut.state), 32'(IDLE));
    check("tmo_sc", 32'(scancode), 32'h1C);
    check("tmo_ec", 32'(err_count), 32'd255);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check("tmo_rdy", n_rdy - r0, 1);
    check("tmo_sc2", 32'(scancode), 32'h5A);

    snap();
    ps2_clk = 1'b0;
    idle(2);
    ps2_clk = 1'b1;
    idle(20);
    check("gl_st", 32'(dut.state), 32'(IDLE));
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    check("gl_rdy", n_rdy - r0, 1);
    check("gl_sc", 32'(scancode), 32'h3C);

    snap();
    clk_bit(1'b0);
    clk_bit(1'b1);
    clk_bit(1'b1);
    clk_bit(1'b0);
    clk_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_out", {20'd0, ready, parity_err,
          frame_err, timeout_err, scancode}, 32'd0);
    check("mr_ec", 32'(err_count), 32'd0);
    check("mr_st", 32'(dut.state), 32'(IDLE));
    idle(3);
    rst_n = 1'b1;
    idle(TMO + 10);
    check("mr_nopulse", n_rdy + n_pe + n_fe + n_te
          - r0 - p0 - f0 - t0, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("mr_rdy", n_rdy - r0, 1);
    check("mr_sc", 32'(scancode), 32'h1C);
    check("mr_ec2", 32'(err_count), 32'd0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
